// File: rtl/sim_run_ctrl_pkg.sv
// Shared types and constants for the leoRV simulation run controller.
package sim_run_pkg;

  typedef enum logic [1:0] {
    HOLD = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } run_state_e;

  localparam int unsigned EXIT_PASS = 1;
  localparam logic [31:0] TOHOST_DEFAULT = 32'h0000_1000;

endpackage

// File: rtl/sim_run_ctrl_if.sv
// Core store/retire snoop bundle seen by the run controller.
interface sim_run_ctrl_if #(
   parameter int XLEN = 32
);

   logic            dmem_we;
   logic [XLEN-1:0] dmem_addr;
   logic [XLEN-1:0] dmem_wdata;
   logic            retire;

   modport master (
      output dmem_we,
      output dmem_addr,
      output dmem_wdata,
      output retire
   );

   modport slave (
      input dmem_we,
      input dmem_addr,
      input dmem_wdata,
      input retire
   );

endinterface

// File: rtl/sim_run_ctrl_sat_counter.sv
// Saturating up-counter with synchronous clear; holds at all-ones.
module sat_counter #(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         en,
   input  logic         clr,
   output logic [W-1:0] q
);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         q <= '0;
      end else if (clr) begin
         q <= '0;
      end else if (en && (q != '1)) begin
         q <= q + 1'b1;
      end
   end

endmodule

// File: rtl/sim_run_ctrl.sv
// Bench run controller: reset sequencing, cycle budget, tohost exit.
// Macro SIM_RUN_CTRL_RETIRE_CNT_EN builds the retire counter.
module sim_run_ctrl
   import sim_run_pkg::*;
#(
   parameter int              XLEN        = 32,
   parameter int              RST_CYCLES  = 4,
   parameter int              MAX_CYCLES  = 1000,
   parameter logic [XLEN-1:0] TOHOST_ADDR = XLEN'(TOHOST_DEFAULT),
   parameter int              CNT_W       = 32
) (
   input  logic             clk,
   input  logic             rst,
   sim_run_ctrl_if.slave    bus,
   output logic             core_rst_n,
   output logic             running,
   output logic             done,
   output logic             pass,
   output logic             timeout,
   output logic [XLEN-1:0]  exit_code,
   output logic [CNT_W-1:0] cycle_cnt,
   output logic [CNT_W-1:0] retire_cnt
);

   localparam logic [1:0] ST_HOLD = HOLD;
   localparam logic [1:0] ST_RUN  = RUN;
   localparam logic [1:0] ST_DONE = DONE;
   localparam int         HW      = $clog2(RST_CYCLES + 1);

   logic [1:0]    state;
   logic [HW-1:0] hold_cnt;
   logic          in_hold;
   logic          in_run;
   logic          hold_last;
   logic          exit_hit;
   logic          last_cyc;
   logic          end_now;
   logic          pass_val;

   assign in_hold   = (state == ST_HOLD);
   assign in_run    = (state == ST_RUN);
   assign hold_last = (hold_cnt == HW'(RST_CYCLES - 1));
   assign exit_hit  = in_run && bus.dmem_we &&
                      (bus.dmem_addr == TOHOST_ADDR);
   assign last_cyc  = (64'(cycle_cnt) == 64'(MAX_CYCLES - 1));
   assign end_now   = exit_hit || last_cyc;
   assign pass_val  = (bus.dmem_wdata == XLEN'(EXIT_PASS));

   // Outputs decode the state register only, so no input reaches them.
   assign core_rst_n = in_run;
   assign running    = in_run;

   sat_counter #(.W(HW)) u_hold (
      .clk   (clk),
      .rst_n (rst),
      .en    (in_hold),
      .clr   (!in_hold),
      .q     (hold_cnt)
   );

   sat_counter #(.W(CNT_W)) u_cycle (
      .clk   (clk),
      .rst_n (rst),
      .en    (in_run && !end_now),
      .clr   (in_hold),
      .q     (cycle_cnt)
   );

`ifdef SIM_RUN_CTRL_RETIRE_CNT_EN
   sat_counter #(.W(CNT_W)) u_retire (
      .clk   (clk),
      .rst_n (rst),
      .en    (in_run && bus.retire),
      .clr   (in_hold),
      .q     (retire_cnt)
   );
`else
   logic unused_retire;
   assign unused_retire = bus.retire;
   assign retire_cnt    = '0;
`endif

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state     <= ST_HOLD;
         done      <= 1'b0;
         pass      <= 1'b0;
         timeout   <= 1'b0;
         exit_code <= '0;
      end else begin
         unique case (1'b1)
            in_hold: begin
               if (hold_last) state <= ST_RUN;
            end
            in_run: begin
               // An exit store on the last budget cycle beats timeout.
               if (exit_hit) begin
                  state     <= ST_DONE;
                  done      <= 1'b1;
                  pass      <= pass_val;
                  exit_code <= bus.dmem_wdata;
               end else if (last_cyc) begin
                  state   <= ST_DONE;
                  done    <= 1'b1;
                  timeout <= 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_sim_run_ctrl.sv
// Randomized bench for sim_run_ctrl against an in-bench run model.
module tb_sim_run_ctrl;

   localparam int RSTC = 4;
`ifdef SIM_RUN_CTRL_RETIRE_CNT_EN
   localparam bit RET_EN = 1'b1;
`else
   localparam bit RET_EN = 1'b0;
`endif
   localparam int MAXC [3] = '{1000, 16, 16};
   localparam longint unsigned CMAX [3] =
      '{64'hFFFF_FFFF, 64'hFFFF_FFFF, 64'hF};
   localparam logic [31:0] TOHOST = 32'h0000_1000;

   logic clk = 1'b0;
   logic rst;
   logic we;
   logic [31:0] addr;
   logic [31:0] wdata;
   logic retire;

   int checks = 0;
   int failures = 0;

   always #5 clk = ~clk;

   sim_run_ctrl_if #(.XLEN(32)) bus_a ();
   sim_run_ctrl_if #(.XLEN(32)) bus_b ();
   sim_run_ctrl_if #(.XLEN(32)) bus_c ();

   assign bus_a.dmem_we = we;
   assign bus_a.dmem_addr = addr;
   assign bus_a.dmem_wdata = wdata;
   assign bus_a.retire = retire;
   assign bus_b.dmem_we = we;
   assign bus_b.dmem_addr = addr;
   assign bus_b.dmem_wdata = wdata;
   assign bus_b.retire = retire;
   assign bus_c.dmem_we = we;
   assign bus_c.dmem_addr = addr;
   assign bus_c.dmem_wdata = wdata;
   assign bus_c.retire = retire;

   logic a_crn, a_run, a_done, a_pass, a_to;
   logic [31:0] a_code, a_cyc, a_ret;
   logic b_crn, b_run, b_done, b_pass, b_to;
   logic [31:0] b_code, b_cyc, b_ret;
   logic c_crn, c_run, c_done, c_pass, c_to;
   logic [31:0] c_code;
   logic [3:0] c_cyc, c_ret;

   sim_run_ctrl #(
      .XLEN(32), .RST_CYCLES(RSTC), .MAX_CYCLES(1000),
      .TOHOST_ADDR(TOHOST), .CNT_W(32)
   ) u_a (
      .clk(clk), .rst(rst), .bus(bus_a),
      .core_rst_n(a_crn), .running(a_run), .done(a_done),
      .pass(a_pass), .timeout(a_to), .exit_code(a_code),
      .cycle_cnt(a_cyc), .retire_cnt(a_ret)
   );

   sim_run_ctrl #(
      .XLEN(32), .RST_CYCLES(RSTC), .MAX_CYCLES(16),
      .TOHOST_ADDR(TOHOST), .CNT_W(32)
   ) u_b (
      .clk(clk), .rst(rst), .bus(bus_b),
      .core_rst_n(b_crn), .running(b_run), .done(b_done),
      .pass(b_pass), .timeout(b_to), .exit_code(b_code),
      .cycle_cnt(b_cyc), .retire_cnt(b_ret)
   );

   sim_run_ctrl #(
      .XLEN(32), .RST_CYCLES(RSTC), .MAX_CYCLES(16),
      .TOHOST_ADDR(TOHOST), .CNT_W(4)
   ) u_c (
      .clk(clk), .rst(rst), .bus(bus_c),
      .core_rst_n(c_crn), .running(c_run), .done(c_done),
      .pass(c_pass), .timeout(c_to), .exit_code(c_code),
      .cycle_cnt(c_cyc), .retire_cnt(c_ret)
   );

   // Run model: edges since release, run flag, result registers.
   int hold_e [3];
   bit m_run [3];
   bit m_done [3];
   bit m_pass [3];
   bit m_to [3];
   longint unsigned m_cyc [3];
   longint unsigned m_ret [3];
   logic [31:0] m_code [3];

   function automatic void model_reset();
      for (int i = 0; i < 3; i++) begin
         hold_e[i] = 0;
         m_run[i] = 0;
         m_done[i] = 0;
         m_pass[i] = 0;
         m_to[i] = 0;
         m_cyc[i] = 0;
         m_ret[i] = 0;
         m_code[i] = '0;
      end
   endfunction

   function automatic void model_step();
      if (!rst) begin
         model_reset();
         return;
      end
      for (int i = 0; i < 3; i++) begin
         if (m_done[i]) continue;
         if (!m_run[i]) begin
            hold_e[i]++;
            if (hold_e[i] == RSTC) begin
               m_run[i] = 1;
               m_cyc[i] = 0;
               m_ret[i] = 0;
            end
            continue;
         end
         if (RET_EN && retire && m_ret[i] < CMAX[i]) m_ret[i]++;
         if (we && addr == TOHOST) begin
            m_done[i] = 1;
            m_run[i] = 0;
            m_pass[i] = (wdata == 32'd1);
            m_code[i] = wdata;
         end else if (m_cyc[i] == longint'(MAXC[i] - 1)) begin
            m_done[i] = 1;
            m_run[i] = 0;
            m_to[i] = 1;
         end else if (m_cyc[i] < CMAX[i]) begin
            m_cyc[i]++;
         end
      end
   endfunction

   task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h t=%0t",
                  nm, act, exp, $time);
      end
   endtask

   task automatic check_inst(int i);
      logic crn, run, dn, ps, to;
      logic [63:0] code, cyc, ret;
      case (i)
         0: begin
            crn = a_crn; run = a_run; dn = a_done; ps = a_pass;
            to = a_to; code = 64'(a_code); cyc = 64'(a_cyc);
            ret = 64'(a_ret);
         end
         1: begin
            crn = b_crn; run = b_run; dn = b_done; ps = b_pass;
            to = b_to; code = 64'(b_code); cyc = 64'(b_cyc);
            ret = 64'(b_ret);
         end
         default: begin
            crn = c_crn; run = c_run; dn = c_done; ps = c_pass;
            to = c_to; code = 64'(c_code); cyc = 64'(c_cyc);
            ret = 64'(c_ret);
         end
      endcase
      chk($sformatf("core_rst_n_%0d", i), 64'(crn), 64'(m_run[i]));
      chk($sformatf("running_%0d", i), 64'(run), 64'(m_run[i]));
      chk($sformatf("done_%0d", i), 64'(dn), 64'(m_done[i]));
      chk($sformatf("pass_%0d", i), 64'(ps), 64'(m_pass[i]));
      chk($sformatf("timeout_%0d", i), 64'(to), 64'(m_to[i]));
      chk($sformatf("exit_code_%0d", i), code, 64'(m_code[i]));
      chk($sformatf("cycle_cnt_%0d", i), cyc, m_cyc[i]);
      chk($sformatf("retire_cnt_%0d", i), ret, m_ret[i]);
   endtask

   task automatic check_all();
      for (int i = 0; i < 3; i++) check_inst(i);
   endtask

   task automatic tick();
      @(posedge clk);
      model_step();
      #1;
      check_all();
      @(negedge clk);
   endtask

   task automatic idle();
      we = 0;
      addr = 32'h0;
      wdata = 32'h0;
   endtask

   task automatic do_reset();
      rst = 0;
      #1;
      model_reset();
      check_all();
   endtask

   task automatic bound_fail(string nm);
      checks++;
      failures++;
      $display("FAIL bound_%s actual=expired required=reached", nm);
   endtask

   task automatic run_until_cyc(int i, longint unsigned n);
      int k = 0;
      while (!(m_run[i] && m_cyc[i] == n) && k < 2000) begin
         tick();
         k++;
      end
      if (k >= 2000) bound_fail("run_until_cyc");
   endtask

   initial begin
      rst = 0;
      retire = 0;
      idle();
      model_reset();
      @(negedge clk);
      tick();
      tick();
      chk("lit_reset_crn", 64'(a_crn), 64'd0);
      chk("lit_reset_done", 64'(a_done), 64'd0);
      chk("lit_reset_cyc", 64'(a_cyc), 64'd0);

      // Release with three retires during HOLD.
      rst = 1;
      retire = 1;
      repeat (3) tick();
      chk("lit_hold_edge3_crn", 64'(a_crn), 64'd0);
      retire = 0;
      tick();
      chk("lit_release_crn", 64'(a_crn), 64'd1);
      chk("lit_release_run", 64'(a_run), 64'd1);
      chk("lit_release_cyc", 64'(a_cyc), 64'd0);
      retire = 1;
      repeat (10) tick();
      retire = 0;
      for (int k = 0; k < 20 && m_cyc[0] != 20; k++) begin
         we = 1'($urandom_range(1));
         addr = TOHOST + 32'($urandom_range(1, 255)) * 4;
         wdata = 32'd1;
         tick();
      end
      run_until_cyc(0, 20);
      we = 1;
      addr = TOHOST;
      wdata = 32'd1;
      tick();
      chk("lit_pass_done", 64'(a_done), 64'd1);
      chk("lit_pass_pass", 64'(a_pass), 64'd1);
      chk("lit_pass_to", 64'(a_to), 64'd0);
      chk("lit_pass_code", 64'(a_code), 64'd1);
      chk("lit_pass_cyc", 64'(a_cyc), 64'd20);
      chk("lit_ret10", 64'(a_ret), RET_EN ? 64'd10 : 64'd0);
      chk("lit_tmo_to", 64'(b_to), 64'd1);
      chk("lit_tmo_pass", 64'(b_pass), 64'd0);
      chk("lit_tmo_cyc", 64'(b_cyc), 64'd15);
      wdata = 32'd7;
      tick();
      chk("lit_sticky_code", 64'(a_code), 64'd1);
      idle();

      // Async reset mid-run, then a failing exit code.
      do_reset();
      tick();
      rst = 1;
      run_until_cyc(0, 5);
      do_reset();
      chk("lit_async_crn", 64'(a_crn), 64'd0);
      chk("lit_async_run", 64'(a_run), 64'd0);
      chk("lit_async_cyc", 64'(a_cyc), 64'd0);
      tick();
      rst = 1;
      run_until_cyc(0, 3);
      we = 1;
      addr = TOHOST;
      wdata = 32'd7;
      tick();
      chk("lit_fail_pass", 64'(a_pass), 64'd0);
      chk("lit_fail_code", 64'(a_code), 64'd7);
      wdata = 32'd1;
      tick();
      chk("lit_fail_sticky", 64'(a_code), 64'd7);
      idle();

      // Exit store on the final budget cycle.
      do_reset();
      tick();
      rst = 1;
      run_until_cyc(1, 15);
      we = 1;
      addr = TOHOST;
      wdata = 32'd1;
      tick();
      chk("lit_tie_pass", 64'(b_pass), 64'd1);
      chk("lit_tie_to", 64'(b_to), 64'd0);
      chk("lit_tie_cyc", 64'(b_cyc), 64'd15);
      idle();

      // Retire every cycle until timeout: narrow counter saturates.
      do_reset();
      tick();
      rst = 1;
      retire = 1;
      for (int k = 0; k < 40 && !m_done[2]; k++) tick();
      if (!m_done[2]) bound_fail("saturate");
      retire = 0;
      chk("lit_sat_c", 64'(c_ret), RET_EN ? 64'd15 : 64'd0);
      chk("lit_sat_b", 64'(b_ret), RET_EN ? 64'd16 : 64'd0);
      chk("lit_sat_to", 64'(c_to), 64'd1);

      // Randomized runs.
      for (int r = 0; r < 30; r++) begin
         do_reset();
         repeat ($urandom_range(1, 3)) tick();
         rst = 1;
         for (int k = 0; k < 60; k++) begin
            we = ($urandom_range(7) == 0);
            addr = $urandom_range(1) ? TOHOST : $urandom();
            wdata = $urandom_range(1) ? 32'd1 : $urandom();
            retire = 1'($urandom_range(1));
            if ($urandom_range(99) == 0) begin
               do_reset();
               tick();
               rst = 1;
            end else begin
               tick();
            end
         end
      end
      idle();
      retire = 0;

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/sim_run_ctrl.md
# sim_run_ctrl

Parametrised run controller for leoRV simulation benches: sequences core reset release, bounds the run with a cycle budget, and ends the run on a store to a tohost address. It replaces the fixed-delay clock/finish pattern with a measurable pass/fail/timeout result. It sits beside `top_level` in the bench, drives the core's reset and snoops its data-memory write port and retire pulse.

## Interface
- `XLEN`, 32, data/address width of the snooped store port
- `RST_CYCLES`, 4, cycles the core is held in reset after `rst` deasserts (≥1)
- `MAX_CYCLES`, 1000, RUN-state cycle budget before timeout (≥1)
- `TOHOST_ADDR`, 32'h0000_1000, exit-mailbox byte address
- `CNT_W`, 32, width of cycle and retire counters
- `clk` in 1 — single clock; all logic rising-edge
- `rst` in 1 — asynchronous, active-low reset
- `dmem_we` in 1 — core data-memory write enable
- `dmem_addr` in XLEN — core store address
- `dmem_wdata` in XLEN — core store data
- `retire` in 1 — one-cycle pulse per retired instruction
- `core_rst_n` out 1 — active-low reset to the core
- `running` out 1 — high in RUN
- `done` out 1 — sticky end-of-run flag
- `pass` out 1 — valid when `done`
- `timeout` out 1 — valid when `done`
- `exit_code` out XLEN — captured tohost value
- `cycle_cnt` out CNT_W — RUN cycles elapsed
- `retire_cnt` out CNT_W — instructions retired in RUN

## Operation
- FSM states: HOLD, RUN, DONE. `rst` low forces HOLD with hold counter 0.
- HOLD: `core_rst_n`=0; hold counter increments; after RST_CYCLES cycles go RUN.
- RUN: `core_rst_n`=1, `running`=1; `cycle_cnt` increments each cycle.
- Exit on `dmem_we`=1 and `dmem_addr`==TOHOST_ADDR in RUN: capture `dmem_wdata` into `exit_code`; `pass`=1 iff wdata==1; go DONE.
- Timeout: in RUN when `cycle_cnt`==MAX_CYCLES-1 and no exit store → DONE, `timeout`=1, `pass`=0, `exit_code`=0.
- Exit store and timeout in the same cycle: exit store wins, `timeout`=0.
- DONE: sticky until `rst`; `core_rst_n`=0 (core parked), counters frozen, further stores ignored.
- Stores and retire pulses during HOLD/DONE ignored.
- Stores to other addresses ignored; no byte-enable decode, full-word compare.
- Counters saturate at all-ones, never wrap.

## Timing
- Reset values: `core_rst_n`=0, `running`=0, `done`=0, `pass`=0, `timeout`=0, `exit_code`=0, `cycle_cnt`=0, `retire_cnt`=0.
- `core_rst_n` rises on edge RST_CYCLES after the first edge with `rst` high.
- `cycle_cnt`=0 in first RUN cycle; equals k in the (k+1)-th RUN cycle.
- Exit store sampled at edge N → `done`, `pass`, `exit_code` valid after edge N; `running` low same edge.
- `retire` sampled in a RUN cycle counts; the terminating cycle's retire counts.
- `rst` asserted mid-run: all outputs return to reset values immediately (asynchronous).
- All outputs registered; no combinational input-to-output path.

## Configuration
- `SIM_RUN_CTRL_RETIRE_CNT_EN` defined: retire counter built, `retire_cnt` live as above.
- Undefined: counter and `retire` logic removed; `retire_cnt` tied to 0; `retire` input unused.

## Structure
- Package `sim_run_pkg`: state enum (HOLD/RUN/DONE), `EXIT_PASS`=1 constant, default TOHOST address.
- Sub-module `sat_counter` (width, enable, clear, saturating increment) instantiated for hold, cycle and retire counters.

## Test plan
- RST_CYCLES=4; release `rst` → `core_rst_n` rises exactly 4 edges later, `running`=1, `cycle_cnt`=0.
- Store 1 to 0x1000 at RUN cycle 20 → next cycle `done`=1, `pass`=1, `timeout`=0, `exit_code`=1, `cycle_cnt`=20.
- Store 0x0000_0007 to 0x1000 → `done`=1, `pass`=0, `exit_code`=7; later stores leave it at 7.
- MAX_CYCLES=16, no exit store → `done`=1, `timeout`=1, `pass`=0, `cycle_cnt`=15; exit store on cycle 15 → `pass`=1, `timeout`=0.
- Retire pulses every cycle for 10 RUN cycles plus 3 during HOLD → `retire_cnt`=10 (0 with macro undefined); CNT_W=4 run of 20 retires → saturates at 15.
- Drop `rst` mid-RUN → all outputs zero asynchronously, `core_rst_n`=0, HOLD sequence restarts on release.
